vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 28 ++
 rtl/sync_delay.sv | 30 +++
 rtl/vga_timing_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 720p video timing constants and the timing-parameter record used by
// the timing generator and the video driver.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    localparam vga_timing_t H_720P = '{active: 16'd1280, fp: 16'd110, sync: 16'd40, bp: 16'd220};
    localparam vga_timing_t V_720P = '{active: 16'd720,  fp: 16'd5,   sync: 16'd5,  bp: 16'd20};

    localparam int SCALE_X_720P = 5;
    localparam int SCALE_Y_720P = 4;
    localparam int FB_LAT_DEF   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_t;

    function automatic int timing_total(input vga_timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth register pipeline; every stage resets asynchronously to RST_VAL.
module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Video raster timing generator: line/frame counters, render-grid addressing
// without dividers, and sync/de delayed to line up with framebuffer read data.
//
// state   | meaning
// ST_IDLE | out of reset; counters parked at 0, first edge loads pixel (0,0)
// ST_RUN  | free-running raster
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = int'(H_720P.active),
    parameter int H_FP      = int'(H_720P.fp),
    parameter int H_SYNC    = int'(H_720P.sync),
    parameter int H_BP      = int'(H_720P.bp),
    parameter int V_ACTIVE  = int'(V_720P.active),
    parameter int V_FP      = int'(V_720P.fp),
    parameter int V_SYNC    = int'(V_720P.sync),
    parameter int V_BP      = int'(V_720P.bp),
    parameter bit SYNC_POL  = 1'b1,
    parameter int X_SCALE   = SCALE_X_720P,
    parameter int Y_SCALE   = SCALE_Y_720P,
    parameter int RCoorBits = 8,
    parameter int FB_LAT    = FB_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [RCoorBits-1:0] rendx,
    output logic [RCoorBits-1:0] rendy,
    output logic                 rend_req,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 de_out,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XSW     = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
    localparam int YSW     = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;

    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HX_LAST  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [VW-1:0] V_ONE    = VW'(1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VY_LAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [XSW-1:0]       XSUB_ONE  = XSW'(1);
    localparam logic [XSW-1:0]       XSUB_LAST = XSW'(X_SCALE - 1);
    localparam logic [YSW-1:0]       YSUB_ONE  = YSW'(1);
    localparam logic [YSW-1:0]       YSUB_LAST = YSW'(Y_SCALE - 1);
    localparam logic [RCoorBits-1:0] R_ONE     = RCoorBits'(1);

    gen_state_t     state, state_nxt;
    logic           running;
    logic [HW-1:0]  hcnt, hcnt_nxt;
    logic [VW-1:0]  vcnt, vcnt_nxt;
    logic           line_end, frame_end;
    logic           act_nxt, hs_nxt, vs_nxt;
    logic           hs_q, vs_q;
    logic [XSW-1:0] xsub;
    logic [YSW-1:0] ysub;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        running = (state == ST_RUN);
    end

    always_comb begin
        hcnt_nxt  = hcnt;
        vcnt_nxt  = vcnt;
        line_end  = running && (hcnt == H_LAST);
        frame_end = line_end && (vcnt == V_LAST);
        if (running) begin
            if (hcnt == H_LAST) begin
                hcnt_nxt = '0;
                vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + V_ONE;
            end else begin
                hcnt_nxt = hcnt + H_ONE;
            end
        end
        act_nxt = (hcnt_nxt < H_ACT_C) && (vcnt_nxt < V_ACT_C);
        hs_nxt  = (hcnt_nxt >= HS_FIRST) && (hcnt_nxt <= HS_LAST);
        vs_nxt  = (vcnt_nxt >= VS_FIRST) && (vcnt_nxt <= VS_LAST);
    end

    // Flags are registered from the next counter values so they line up
    // with the counters themselves rather than trailing them by a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            rend_req    <= 1'b0;
            frame_start <= 1'b0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
        end else begin
            hcnt        <= hcnt_nxt;
            vcnt        <= vcnt_nxt;
            rend_req    <= act_nxt;
            frame_start <= (hcnt_nxt == '0) && (vcnt_nxt == '0);
            hs_q        <= hs_nxt ? SYNC_POL : ~SYNC_POL;
            vs_q        <= vs_nxt ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Sub-counters stop on the last active column/row so rendx/rendy hold
    // their final value through blanking instead of overrunning the grid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xsub  <= '0;
            rendx <= '0;
        end else if (line_end) begin
            xsub  <= '0;
            rendx <= '0;
        end else if (running && (hcnt < HX_LAST)) begin
            if (xsub == XSUB_LAST) begin
                xsub  <= '0;
                rendx <= rendx + R_ONE;
            end else begin
                xsub <= xsub + XSUB_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ysub  <= '0;
            rendy <= '0;
        end else if (frame_end) begin
            ysub  <= '0;
            rendy <= '0;
        end else if (line_end && (vcnt < VY_LAST)) begin
            if (ysub == YSUB_LAST) begin
                ysub  <= '0;
                rendy <= rendy + R_ONE;
            end else begin
                ysub <= ysub + YSUB_ONE;
            end
        end
    end

    generate
        if (FB_LAT == 0) begin : g_no_lat
            assign hsync_out = hs_q;
            assign vsync_out = vs_q;
            assign de_out    = rend_req;
        end else begin : g_lat
            sync_delay #(
                .WIDTH   (3),
                .DEPTH   (FB_LAT),
                .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
            ) u_delay (
                .clk   (clk),
                .rst_n (rst),
                .d     ({hs_q, vs_q, rend_req}),
                .q     ({hsync_out, vsync_out, de_out})
            );
        end
    endgenerate

endmodule
